// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types for the load/store memory stage.
// FSM state enum, funct3 encodings, error bundle, size legality helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic misaligned;
    logic illegal;
    logic bus_err;
  } lsu_err_t;

  // Unsigned widths only exist for loads.
  function automatic logic size_legal(
    input logic [2:0] f,
    input logic       is_store
  );
    logic ok;
    case (f)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// lsu_mem_stage_if: data-memory request/grant/response bus.
// master = LSU side (drives req/we/addr/be/wdata), slave = memory side.
interface lsu_mem_stage_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_gnt,
    input  dmem_rvalid,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_gnt,
    output dmem_rvalid,
    output dmem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the LSU.
// in: fn3, off, store_data, rdata; out: be, wdata, load_data.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  fn3,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Halves are only issued at offsets 0 or 2.
  assign lane_b = rdata[{off, 3'b000} +: 8];
  assign lane_h = rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    unique case (1'b1)
      fn3[1:0] == 2'b00: begin
        be    = 4'b0001 << off;
        wdata = {4{store_data[7:0]}};
      end
      fn3[1:0] == 2'b01: begin
        be    = 4'b0011 << off;
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_data = rdata;
    unique case (1'b1)
      fn3 == F3_B:  load_data = {{24{lane_b[7]}}, lane_b};
      fn3 == F3_BU: load_data = {24'b0, lane_b};
      fn3 == F3_H:  load_data = {{16{lane_h[15]}}, lane_h};
      fn3 == F3_HU: load_data = {16'b0, lane_h};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: one data-memory access per start, with timeout.
// in: clk, rst_n, start, mem_read/write, fn3, addr, store_data;
// bus: dmem (master); out: busy, done, load_data, error flags.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [2:0]             fn3,
  input  logic [31:0]            addr,
  input  logic [31:0]            store_data,
  lsu_mem_stage_if.master        dmem,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            load_data,
  output logic                   misaligned,
  output logic                   illegal,
  output logic                   bus_err
);

  localparam logic [9:0] TO_LAST =
    10'(TIMEOUT_CYCLES - 1);

  lsu_state_t state, state_nxt;

  logic        accept;
  logic        rw_bad;
  logic        mis_in;
  logic        in_xfer;
  logic        to_hit;
  logic [9:0]  cnt;

  logic [31:0] addr_q;
  logic [2:0]  fn3_q;
  logic [31:0] sd_q;
  logic        we_q;
  logic [31:0] ld_q;
  lsu_err_t    err_q;

  logic [3:0]  be_w;
  logic [31:0] wdata_w;
  logic [31:0] ext_w;

  logic        req_o;
  logic        done_o;

  assign accept  = (state == S_IDLE) & start
                 & (mem_read | mem_write);
  assign rw_bad  = (mem_read & mem_write)
                 | !size_legal(fn3, mem_write);
  assign mis_in  = ((fn3[1:0] == 2'b01) & addr[0])
                 | ((fn3[1:0] == 2'b10) & (|addr[1:0]));
  assign in_xfer = (state == S_REQ) | (state == S_WAIT);
  // Timeout wins over a gnt/rvalid landing on the last cycle.
  assign to_hit  = in_xfer & (cnt == TO_LAST);

  lsu_align u_align (
    .fn3        (fn3_q),
    .off        (addr_q[1:0]),
    .store_data (sd_q),
    .rdata      (dmem.dmem_rdata),
    .be         (be_w),
    .wdata      (wdata_w),
    .load_data  (ext_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept)
          state_nxt = (rw_bad | mis_in) ? S_RESP : S_REQ;
      end
      S_REQ: begin
        if (to_hit)             state_nxt = S_RESP;
        else if (dmem.dmem_gnt) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (to_hit)                state_nxt = S_RESP;
        else if (dmem.dmem_rvalid) state_nxt = S_RESP;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_o  = 1'b0;
    done_o = 1'b0;
    unique case (state)
      S_REQ:   req_o  = 1'b1;
      S_RESP:  done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      fn3_q  <= '0;
      sd_q   <= '0;
      we_q   <= 1'b0;
      cnt    <= '0;
      ld_q   <= '0;
      err_q  <= '0;
    end else begin
      if (accept) begin
        addr_q <= addr;
        fn3_q  <= fn3;
        sd_q   <= store_data;
        we_q   <= mem_write;
        cnt    <= '0;
        if (rw_bad) begin
          err_q <= '{misaligned: 1'b0,
                     illegal:    1'b1,
                     bus_err:    1'b0};
        end else if (mis_in) begin
          err_q <= '{misaligned: 1'b1,
                     illegal:    1'b0,
                     bus_err:    1'b0};
        end
      end
      if (in_xfer) begin
        cnt <= cnt + 10'd1;
        if (to_hit) begin
          err_q <= '{misaligned: 1'b0,
                     illegal:    1'b0,
                     bus_err:    1'b1};
        end else if ((state == S_WAIT)
                     && dmem.dmem_rvalid) begin
          err_q <= '0;
          if (!we_q) ld_q <= ext_w;
        end
      end
    end
  end

  assign dmem.dmem_req   = req_o;
  assign dmem.dmem_we    = req_o & we_q;
  assign dmem.dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem.dmem_be    = req_o ? be_w : 4'b0000;
  assign dmem.dmem_wdata = wdata_w;

  // Stall goes up combinationally in the accepting cycle.
  assign busy       = rst_n & ((state != S_IDLE) | accept);
  assign done       = done_o;
  assign load_data  = ld_q;
  assign misaligned = err_q.misaligned;
  assign illegal    = err_q.illegal;
  assign bus_err    = err_q.bus_err;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: randomized bench with a transaction-level model.
// Drives core and memory sides, compares every cycle at negedge.
module tb_lsu_mem_stage;

  localparam int T = 8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  fn3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        illegal;
  logic        bus_err;

  lsu_mem_stage_if bus ();

  lsu_mem_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .fn3        (fn3),
    .addr       (addr),
    .store_data (store_data),
    .dmem       (bus),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .misaligned (misaligned),
    .illegal    (illegal),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  int checks;
  int failures;
  int req_cycles;

  logic        e_busy, e_done, e_req, e_we;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_be;
  logic [31:0] m_load;
  logic        m_mis, m_ill, m_berr;

  logic [3:0]  last_be;
  logic [31:0] last_wdata, last_addr;

  task automatic check1(input string nm,
                        input logic act,
                        input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic check32(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check1("busy", busy, e_busy);
      check1("done", done, e_done);
      check1("dmem_req", bus.dmem_req, e_req);
      check32("load_data", load_data, m_load);
      check1("misaligned", misaligned, m_mis);
      check1("illegal", illegal, m_ill);
      check1("bus_err", bus_err, m_berr);
      if (bus.dmem_req) begin
        req_cycles++;
        last_be    = bus.dmem_be;
        last_wdata = bus.dmem_wdata;
        last_addr  = bus.dmem_addr;
      end
      if (e_req) begin
        check1("dmem_we", bus.dmem_we, e_we);
        check32("dmem_addr", bus.dmem_addr, e_addr);
        check32("dmem_be", 32'(bus.dmem_be), 32'(e_be));
        check32("dmem_wdata", bus.dmem_wdata, e_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    start      = 1'($urandom % 2);
    mem_read   = 1'($urandom);
    mem_write  = 1'($urandom);
    fn3        = 3'($urandom);
    addr       = $urandom;
    store_data = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start      = 1'($urandom % 2);
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      fn3        = 3'($urandom);
      addr       = $urandom;
      store_data = $urandom;
      bus.dmem_gnt    = 1'b0;
      bus.dmem_rvalid = 1'($urandom % 2);
      bus.dmem_rdata  = $urandom;
      e_busy = 1'b0;
      e_done = 1'b0;
      e_req  = 1'b0;
      tick();
    end
  endtask

  // g: REQ cycles before the gnt cycle; r: cycles from gnt to rvalid.
  task automatic do_txn(input bit rd, input bit wr,
                        input logic [2:0] f,
                        input logic [31:0] a,
                        input logic [31:0] sd,
                        input int g, input int r,
                        input logic [31:0] word);
    int o, sz, kend;
    bit ill, mis, tmo;
    logic [31:0] xbe, xwd, v;
    o  = int'(a[1:0]);
    sz = int'(f) % 4;
    ill = (rd && wr) || (f == 3'd3) || (f == 3'd6)
       || (f == 3'd7) || (wr && f >= 3'd4);
    mis = !ill && ((sz == 1 && (o % 2) != 0)
                   || (sz == 2 && o != 0));
    if (sz == 0) begin
      xbe = 32'd1 << o;
      xwd = (sd & 32'hFF) * 32'h0101_0101;
    end else if (sz == 1) begin
      xbe = 32'd3 << o;
      xwd = (sd & 32'hFFFF) * 32'h0001_0001;
    end else begin
      xbe = 32'd15;
      xwd = sd;
    end
    v = word >> (8 * o);
    if (sz == 0) begin
      v = v & 32'hFF;
      if (f == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = v & 32'hFFFF;
      if (f == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end

    start      = 1'b1;
    mem_read   = rd;
    mem_write  = wr;
    fn3        = f;
    addr       = a;
    store_data = sd;
    bus.dmem_gnt    = 1'b0;
    bus.dmem_rvalid = 1'($urandom % 2);
    bus.dmem_rdata  = $urandom;
    e_busy = 1'b1;
    e_done = 1'b0;
    e_req  = 1'b0;
    tick();

    if (ill || mis) begin
      noise();
      e_done = 1'b1;
      m_ill  = ill;
      m_mis  = mis;
      m_berr = 1'b0;
      tick();
      return;
    end

    tmo  = (g + r >= T - 1);
    kend = tmo ? T - 1 : g + r;
    e_we    = wr;
    e_addr  = a & ~32'h3;
    e_be    = xbe[3:0];
    e_wdata = xwd;
    for (int k = 0; k <= kend; k++) begin
      noise();
      e_req  = (k <= g);
      e_busy = 1'b1;
      e_done = 1'b0;
      bus.dmem_gnt = (k == g);
      bus.dmem_rvalid = (k == g + r) ? 1'b1 :
                        (k < g) ? 1'($urandom % 2) : 1'b0;
      bus.dmem_rdata = (k == g + r) ? word : $urandom;
      tick();
    end

    noise();
    bus.dmem_gnt    = 1'b0;
    bus.dmem_rvalid = 1'($urandom % 2);
    e_req  = 1'b0;
    e_done = 1'b1;
    e_busy = 1'b1;
    m_mis  = 1'b0;
    m_ill  = 1'b0;
    m_berr = tmo;
    if (!tmo && rd) m_load = v;
    tick();
  endtask

  initial begin
    int rc0, kind, g, r, sel;
    logic [2:0] f;
    logic [31:0] a;
    logic [2:0] legal_f [5];
    legal_f = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    checks = 0;
    failures = 0;
    req_cycles = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    fn3 = '0;
    addr = '0;
    store_data = '0;
    bus.dmem_gnt = 1'b0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata = '0;
    e_busy = 0; e_done = 0; e_req = 0; e_we = 0;
    e_addr = '0; e_wdata = '0; e_be = '0;
    m_load = '0; m_mis = 0; m_ill = 0; m_berr = 0;
    last_be = '0; last_wdata = '0; last_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    do_txn(0, 1, 3'd2, 32'h1000_0004, 32'hDEAD_BEEF,
           0, 1, 32'h1234_5678);
    check32("sw_addr_lit", last_addr, 32'h1000_0004);
    check32("sw_be_lit", 32'(last_be), 32'hF);
    check32("sw_wdata_lit", last_wdata, 32'hDEAD_BEEF);
    check32("sw_ld_keep_lit", load_data, 32'h0);
    idle(1);

    do_txn(1, 0, 3'd0, 32'h23, 32'h0, 0, 1, 32'h8011_2233);
    check32("lb_be_lit", 32'(last_be), 32'h8);
    check32("lb_lit", load_data, 32'hFFFF_FF80);
    do_txn(1, 0, 3'd4, 32'h23, 32'h0, 1, 2, 32'h8011_2233);
    check32("lbu_lit", load_data, 32'h0000_0080);

    do_txn(0, 1, 3'd1, 32'h42, 32'h0000_ABCD, 0, 1, 32'h0);
    check32("sh_be_lit", 32'(last_be), 32'hC);
    check32("sh_wdata_lit", last_wdata, 32'hABCD_ABCD);
    do_txn(1, 0, 3'd1, 32'h42, 32'h0, 0, 1, 32'h8001_7FFF);
    check32("lh_lit", load_data, 32'hFFFF_8001);

    rc0 = req_cycles;
    do_txn(1, 0, 3'd2, 32'h0000_0012, 32'h0, 0, 1, 32'h0);
    check1("lw_mis_lit", misaligned, 1'b1);
    do_txn(1, 0, 3'd3, 32'h0000_0010, 32'h0, 0, 1, 32'h0);
    check1("f3_ill_lit", illegal, 1'b1);
    idle(1);
    check32("err_noreq_lit", 32'(req_cycles - rc0), 32'd0);

    rc0 = req_cycles;
    do_txn(1, 0, 3'd2, 32'h40, 32'h0, 100, 1, 32'h0);
    check32("tmo_req_lit", 32'(req_cycles - rc0), 32'd8);
    check1("tmo_berr_lit", bus_err, 1'b1);
    check32("tmo_ld_keep_lit", load_data, 32'hFFFF_8001);
    idle(4);

    // Reset while WAITing for a response.
    start = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    fn3 = 3'd2; addr = 32'h100; store_data = 32'h0;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
    e_busy = 1'b1; e_done = 1'b0; e_req = 1'b0;
    tick();
    noise();
    bus.dmem_gnt = 1'b1;
    e_req = 1'b1; e_we = 1'b0; e_addr = 32'h100;
    e_be = 4'hF; e_wdata = 32'h0;
    tick();
    start = 1'b0;
    bus.dmem_gnt = 1'b0;
    bus.dmem_rvalid = 1'b0;
    e_req = 1'b0;
    #2;
    rst_n = 1'b0;
    e_busy = 1'b0;
    m_load = '0; m_mis = 0; m_ill = 0; m_berr = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata = 32'hCAFE_F00D;
    tick();
    idle(3);

    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom % 16);
      sel  = int'($urandom % 5);
      f = ($urandom % 4 != 0) ? legal_f[sel]
                              : 3'($urandom);
      a = $urandom;
      case ($urandom % 3)
        0: a = a & ~32'h1;
        1: a = a & ~32'h3;
        default: ;
      endcase
      g = ($urandom % 8 == 0) ? int'($urandom_range(4, 12))
                              : int'($urandom % 4);
      r = ($urandom % 8 == 0) ? int'($urandom_range(3, 10))
                              : 1 + int'($urandom % 3);
      do_txn(kind == 0 || kind > 7, kind != 0 && kind <= 7 ||
             kind == 0, f, a, $urandom, g, r, $urandom);
      idle(int'($urandom % 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
